// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end owning the PC, issuing sequential icache requests and buffering {pc, insn} for decode.
//   clk, rst (async, active-low)
//   redirect_valid/redirect_pc/redirect_flush : redirect strobe from execute, flush also pulses cache_flush
//   cache_valid/cache_ready/cache_addr/cache_rdata : icache request port, rdata valid on accept
//   cache_flush : registered one-cycle icache invalidate
//   insn_valid/insn_ready/insn_pc/insn_data : FIFO head toward decode
//   Optional macro FETCH_QUEUE_BYPASS_EN: empty-FIFO bypass of cache_* onto insn_* in the transfer cycle.
module fetch_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        redirect_flush,
  output logic        cache_flush,
  output logic        cache_valid,
  input  logic        cache_ready,
  output logic [31:0] cache_addr,
  input  logic [31:0] cache_rdata,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn_pc,
  output logic [31:0] insn_data
);
  localparam int WORDS = 1 << DEPTH;
  localparam logic [DEPTH:0] FULL = (DEPTH + 1)'(WORDS);
  typedef enum logic {RUN, KILL} state_t;
  state_t state, state_next;
  logic [31:0] pc, pc_next, pending_pc, pending_next, redir_pc;
  logic [31:0] mem_pc [WORDS];
  logic [31:0] mem_data [WORDS];
  logic [DEPTH-1:0] wr_ptr, rd_ptr;
  logic [DEPTH:0] count, count_next;
  logic xfer, push, pop;
  assign redir_pc   = redirect_pc & ~32'd3;
  assign xfer       = cache_valid && cache_ready;
  assign cache_addr = pc;
  assign pop        = (count != '0) && insn_ready;
`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass     = (count == '0) && xfer && state == RUN && !redirect_valid;
  assign insn_valid = (count != '0) || bypass;
  assign insn_pc    = (count == '0) ? pc : mem_pc[rd_ptr];
  assign insn_data  = (count == '0) ? cache_rdata : mem_data[rd_ptr];
  // a bypassed word that decode takes right away never lands in the FIFO
  assign push       = xfer && state == RUN && !redirect_valid && !(bypass && insn_ready);
`else
  assign insn_valid = count != '0;
  assign insn_pc    = mem_pc[rd_ptr];
  assign insn_data  = mem_data[rd_ptr];
  assign push       = xfer && state == RUN && !redirect_valid;
`endif
  // KILL waits out an already-issued request so it is never withdrawn, then jumps to the saved target
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending_pc;
    if (state == RUN) begin
      if (redirect_valid && cache_valid && !xfer) begin
        state_next   = KILL;
        pending_next = redir_pc;
      end else if (redirect_valid) pc_next = redir_pc;
      else if (xfer) pc_next = pc + 32'd4;
    end else begin
      if (redirect_valid) pending_next = redir_pc;
      if (xfer) begin
        state_next = RUN;
        pc_next    = redirect_valid ? redir_pc : pending_pc;
      end
    end
    count_next = redirect_valid ? '0 : count + (DEPTH + 1)'(push) - (DEPTH + 1)'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      pending_pc  <= RESET_PC;
      cache_valid <= 1'b0;
      cache_flush <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      pending_pc  <= pending_next;
      cache_valid <= (cache_valid && !xfer) || (count_next != FULL);
      cache_flush <= redirect_valid && redirect_flush;
      count       <= count_next;
      wr_ptr      <= redirect_valid ? '0 : wr_ptr + DEPTH'(push);
      rd_ptr      <= redirect_valid ? '0 : rd_ptr + DEPTH'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= pc;
      mem_data[wr_ptr] <= cache_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with a combinational memory model.
module tb_fetch_queue;
  logic clk = 0, rst = 0, redirect_valid = 0, redirect_flush = 0, cache_ready = 0, insn_ready = 0;
  logic [31:0] redirect_pc = 0, cache_rdata, cache_addr, insn_pc, insn_data, mon_pc;
  logic cache_flush, cache_valid, insn_valid;
  int vectors = 0, miscompares = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction
  assign cache_rdata = mem(cache_addr);
  fetch_queue #(.DEPTH(2), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_flush(redirect_flush), .cache_flush(cache_flush), .cache_valid(cache_valid),
    .cache_ready(cache_ready), .cache_addr(cache_addr), .cache_rdata(cache_rdata),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_pc(insn_pc), .insn_data(insn_data)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst && insn_valid && insn_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_insn: insn_pc=%h with no expected entry at %0t", insn_pc, $time);
      end else begin
        mon_pc = exp_q.pop_front();
        chk("insn_pc", insn_pc, mon_pc);
        chk("insn_data", insn_data, mem(mon_pc));
      end
    end
  end
  task automatic do_reset();
    rst = 0; redirect_valid = 0; redirect_flush = 0; cache_ready = 0; insn_ready = 0;
    step();
    chk("rst_cache_valid", cache_valid, 0);
    chk("rst_insn_valid", insn_valid, 0);
    chk("rst_cache_flush", cache_flush, 0);
    chk("rst_cache_addr", cache_addr, 32'h100);
  endtask
  task automatic fill(input int n);
    cache_ready = 1; insn_ready = 0;
    repeat (n) step();
    cache_ready = 0;
  endtask
  task automatic drain(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    cache_ready = 0; insn_ready = 1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    insn_ready = 0;
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    step();
    chk("empty_after_drain", insn_valid, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    // streaming from reset
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    cache_ready = 1; insn_ready = 1; rst = 1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      step();
      chk("stream_cache_flush", cache_flush, 0);
    end
    insn_ready = 0;
    chk("stream_left", exp_q.size(), 0);
    exp_q.delete();
    // fill to full, single pop re-opens requests
    do_reset();
    rst = 1; cache_ready = 1;
    repeat (5) step();
    chk("full_cache_valid", cache_valid, 0);
    chk("full_insn_valid", insn_valid, 1);
    chk("full_head_pc", insn_pc, 32'h100);
    chk("full_cache_addr", cache_addr, 32'h110);
    step();
    chk("full_cache_valid2", cache_valid, 0);
    exp_q.push_back(32'h100);
    insn_ready = 1;
    step();
    insn_ready = 0;
    chk("reopen_cache_valid", cache_valid, 1);
    chk("reopen_cache_addr", cache_addr, 32'h110);
    chk("reopen_head_pc", insn_pc, 32'h104);
    chk("reopen_left", exp_q.size(), 0);
    // redirect during a stalled request
    do_reset();
    rst = 1; redirect_valid = 1; redirect_pc = 32'h200;
    step();
    chk("stall_addr1", cache_addr, 32'h200);
    redirect_pc = 32'h400;
    step();
    redirect_valid = 0;
    chk("stall_addr2", cache_addr, 32'h200);
    chk("stall_valid2", cache_valid, 1);
    step();
    chk("stall_addr3", cache_addr, 32'h200);
    cache_ready = 1;
    step();
    chk("after_kill_addr", cache_addr, 32'h400);
    chk("after_kill_valid", cache_valid, 1);
    chk("after_kill_empty", insn_valid, 0);
    fill(6);
    drain(32'h400, 4);
    // two redirects while killing
    do_reset();
    rst = 1; redirect_valid = 1; redirect_pc = 32'h200;
    step();
    redirect_pc = 32'h400;
    step();
    redirect_pc = 32'h800;
    step();
    redirect_valid = 0;
    chk("dbl_addr_held", cache_addr, 32'h200);
    cache_ready = 1;
    step();
    chk("dbl_addr", cache_addr, 32'h800);
    chk("dbl_empty", insn_valid, 0);
    fill(6);
    drain(32'h800, 4);
    // fence.i style redirect to an unaligned target
    redirect_valid = 1; redirect_flush = 1; redirect_pc = 32'h3F;
    chk("flush_before", cache_flush, 0);
    step();
    redirect_valid = 0; redirect_flush = 0;
    chk("flush_pulse", cache_flush, 1);
    step();
    chk("flush_after", cache_flush, 0);
    chk("flush_addr_held", cache_addr, 32'h810);
    cache_ready = 1;
    step();
    cache_ready = 0;
    chk("flush_next_addr", cache_addr, 32'h3C);
    chk("flush_next_valid", cache_valid, 1);
    fill(6);
    drain(32'h3C, 4);
    // async reset while in KILL
    fill(3);
    chk("three_valid", insn_valid, 1);
    chk("three_head", insn_pc, 32'h4C);
    redirect_valid = 1; redirect_flush = 1; redirect_pc = 32'h600;
    step();
    redirect_valid = 0; redirect_flush = 0;
    chk("kill_flush", cache_flush, 1);
    chk("kill_valid", cache_valid, 1);
    chk("kill_addr", cache_addr, 32'h58);
    rst = 0;
    #1;
    chk("async_cache_valid", cache_valid, 0);
    chk("async_cache_flush", cache_flush, 0);
    chk("async_insn_valid", insn_valid, 0);
    chk("async_cache_addr", cache_addr, 32'h100);
    step();
    rst = 1;
    step();
    chk("restart_addr", cache_addr, 32'h100);
    chk("restart_valid", cache_valid, 1);
    fill(6);
    drain(32'h100, 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
